avalon_ctrl_regs: RTL

AVALON_CTRL_REGS -- requirements
Module: avalon_ctrl_regs

---
 rtl/avalon_ctrl_regs_pkg.sv | 23 ++
 rtl/avalon_ctrl_regs_if.sv | 25 ++
 rtl/avalon_ctrl_regs_timer.sv | 85 ++++++++
 rtl/avalon_ctrl_regs.sv | 120 ++++++++++++
 4 files changed

// File: rtl/avalon_ctrl_regs_pkg.sv
// Shared register map, CONTROL/STATUS bit positions and run-timer state encoding.
package avalon_ctrl_pkg;

  localparam int OFF_CONTROL = 0;
  localparam int OFF_STATUS  = 1;
  localparam int OFF_COUNT   = 2;
  localparam int OFF_LIMIT   = 3;
  localparam int OFF_SCRATCH = 4;

  localparam int CTRL_START  = 0;
  localparam int CTRL_STOP   = 1;
  localparam int CTRL_CLR    = 2;
  localparam int CTRL_IRQ_EN = 8;

  localparam int STAT_RUNNING = 0;
  localparam int STAT_DONE    = 1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } run_state_t;

endpackage

// File: rtl/avalon_ctrl_regs_if.sv
// Avalon-MM slave bus bundle; master drives requests, slave returns read data.
interface avalon_ctrl_regs_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4
) ();
  logic [ADDR_W-1:0]   avs_s0_address;
  logic [DATA_W-1:0]   avs_s0_writedata;
  logic [DATA_W/8-1:0] avs_s0_byteenable;
  logic                avs_s0_write;
  logic                avs_s0_read;
  logic [DATA_W-1:0]   avs_s0_readdata;
  logic                avs_s0_readdatavalid;

  modport master (
    output avs_s0_address, avs_s0_writedata, avs_s0_byteenable,
           avs_s0_write, avs_s0_read,
    input  avs_s0_readdata, avs_s0_readdatavalid
  );

  modport slave (
    input  avs_s0_address, avs_s0_writedata, avs_s0_byteenable,
           avs_s0_write, avs_s0_read,
    output avs_s0_readdata, avs_s0_readdatavalid
  );
endinterface

// File: rtl/avalon_ctrl_regs_timer.sv
// Run timer: IDLE/RUN FSM, COUNT, limit compare and entry/exit pulses.
module avalon_run_timer
  import avalon_ctrl_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_wr,
  input  logic              stop_wr,
  input  logic              clr_wr,
  input  logic [DATA_W-1:0] limit,
  output logic              run_o,
  output logic              start_pulse_o,
  output logic              stop_pulse_o,
  output logic              done_set_o,
  output logic [DATA_W-1:0] count_o
);

  run_state_t        state_q, state_d;
  logic [DATA_W-1:0] count_q, count_d;
  logic              sp_q, sp_d, tp_q, tp_d;
  logic              start_eff, hit;

  // STOP in the same write cancels START.
  assign start_eff = start_wr & ~stop_wr;
  // Compare uses the LIMIT register as it stands before this edge.
  assign hit = (state_q == ST_RUN) && (limit != '0) && (count_q == limit - 1'b1);

  // State, count and pulse registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      sp_q    <= 1'b0;
      tp_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      sp_q    <= sp_d;
      tp_q    <= tp_d;
    end
  end

  // Next state, count update and pulse generation.
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    sp_d       = 1'b0;
    tp_d       = 1'b0;
    done_set_o = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_eff) begin
          state_d = ST_RUN;
          count_d = '0;
          sp_d    = 1'b1;
        end else if (clr_wr) begin
          count_d = '0;
        end
      end
      ST_RUN: begin
        if (start_eff) begin
          // Restart: stay in RUN, no pulses.
          count_d = '0;
        end else begin
          if (count_q != '1) count_d = count_q + 1'b1;
          if (stop_wr || hit) begin
            state_d = ST_IDLE;
            tp_d    = 1'b1;
          end
          done_set_o = hit;
          if (clr_wr) count_d = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign run_o         = (state_q == ST_RUN);
  assign start_pulse_o = sp_q;
  assign stop_pulse_o  = tp_q;
  assign count_o       = count_q;

endmodule

// File: rtl/avalon_ctrl_regs.sv
// Control/status register block: bus decode, register file, read mux, run timer.
module avalon_ctrl_regs
  import avalon_ctrl_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 4,
  parameter int NUM_USER = 4
) (
  input  logic              clk,
  input  logic              rst,
  avalon_ctrl_regs_if.slave avs,
  output logic              run_o,
  output logic              start_pulse_o,
  output logic              stop_pulse_o,
  output logic              irq_o
);

  localparam int NB = DATA_W / 8;

  logic                             irq_en_q, done_q;
  logic [DATA_W-1:0]                limit_q, count, rd_mux, rdata_q;
  logic [NUM_USER-1:0][DATA_W-1:0]  scratch_q;
  logic                             rvld_q;
  logic                             ctrl_wr, stat_wr, limit_wr, b0;
  logic                             start_wr, stop_wr, clr_wr, done_set;

  function automatic logic [DATA_W-1:0] be_merge(input logic [DATA_W-1:0] cur,
                                                 input logic [DATA_W-1:0] nxt,
                                                 input logic [NB-1:0]     be);
    be_merge = cur;
    for (int i = 0; i < NB; i++)
      if (be[i]) be_merge[i*8 +: 8] = nxt[i*8 +: 8];
  endfunction

  assign ctrl_wr  = avs.avs_s0_write && (avs.avs_s0_address == ADDR_W'(OFF_CONTROL));
  assign stat_wr  = avs.avs_s0_write && (avs.avs_s0_address == ADDR_W'(OFF_STATUS));
  assign limit_wr = avs.avs_s0_write && (avs.avs_s0_address == ADDR_W'(OFF_LIMIT));
  assign b0       = avs.avs_s0_byteenable[0];

  // Strobes only fire when the low byte lane is written.
  assign start_wr = ctrl_wr && b0 && avs.avs_s0_writedata[CTRL_START];
  assign stop_wr  = ctrl_wr && b0 && avs.avs_s0_writedata[CTRL_STOP];
  assign clr_wr   = ctrl_wr && b0 && avs.avs_s0_writedata[CTRL_CLR];

  avalon_run_timer #(.DATA_W(DATA_W)) u_timer (
    .clk           (clk),
    .rst           (rst),
    .start_wr      (start_wr),
    .stop_wr       (stop_wr),
    .clr_wr        (clr_wr),
    .limit         (limit_q),
    .run_o         (run_o),
    .start_pulse_o (start_pulse_o),
    .stop_pulse_o  (stop_pulse_o),
    .done_set_o    (done_set),
    .count_o       (count)
  );

  // Persistent CONTROL/STATUS/LIMIT bits; a DONE set beats a same-edge W1C.
  always_ff @(posedge clk) begin
    if (rst) begin
      irq_en_q <= 1'b0;
      done_q   <= 1'b0;
      limit_q  <= '0;
    end else begin
      if (ctrl_wr && avs.avs_s0_byteenable[CTRL_IRQ_EN/8])
        irq_en_q <= avs.avs_s0_writedata[CTRL_IRQ_EN];
      if (done_set)
        done_q <= 1'b1;
      else if (stat_wr && b0 && avs.avs_s0_writedata[STAT_DONE])
        done_q <= 1'b0;
      if (limit_wr)
        limit_q <= be_merge(limit_q, avs.avs_s0_writedata, avs.avs_s0_byteenable);
    end
  end

  // Scratch registers, byte-lane writable.
  for (genvar u = 0; u < NUM_USER; u++) begin : g_scr
    always_ff @(posedge clk) begin
      if (rst)
        scratch_q[u] <= '0;
      else if (avs.avs_s0_write && (avs.avs_s0_address == ADDR_W'(OFF_SCRATCH + u)))
        scratch_q[u] <= be_merge(scratch_q[u], avs.avs_s0_writedata, avs.avs_s0_byteenable);
    end
  end

  // Read mux over pre-edge register values; unmapped offsets read 0.
  always_comb begin
    rd_mux = '0;
    case (avs.avs_s0_address)
      ADDR_W'(OFF_CONTROL): rd_mux[CTRL_IRQ_EN] = irq_en_q;
      ADDR_W'(OFF_STATUS): begin
        rd_mux[STAT_RUNNING] = run_o;
        rd_mux[STAT_DONE]    = done_q;
      end
      ADDR_W'(OFF_COUNT):   rd_mux = count;
      ADDR_W'(OFF_LIMIT):   rd_mux = limit_q;
      default: begin
        for (int u = 0; u < NUM_USER; u++)
          if (avs.avs_s0_address == ADDR_W'(OFF_SCRATCH + u)) rd_mux = scratch_q[u];
      end
    endcase
  end

  // One-cycle read response; readdata holds between reads.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= '0;
      rvld_q  <= 1'b0;
    end else begin
      rvld_q <= avs.avs_s0_read;
      if (avs.avs_s0_read) rdata_q <= rd_mux;
    end
  end

  assign avs.avs_s0_readdata      = rdata_q;
  assign avs.avs_s0_readdatavalid = rvld_q;
  assign irq_o                    = done_q & irq_en_q;

endmodule
